// File: rtl/equalizer_pkg.sv
// Shared definitions for the equalizer datapath blocks.
//   - FSM state encoding for tap_accumulator (ACCUM=0, OUT=1)
//   - acc_width(): accumulator width for TAPS products of two N-bit operands
package equalizer_pkg;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_OUT   = 1'b1;

  // Each product needs 2*n bits. Summing taps of them needs clog2(taps)
  // extra bits so that taps*(2^n-1)^2 cannot overflow.
  function automatic int acc_width(input int n, input int taps);
    return 2 * n + $clog2(taps);
  endfunction

endpackage

// File: rtl/tap_accumulator.sv
// tap_accumulator: sums TAPS unsigned products from an external multiplier
// into one output sample, with valid/ready handshakes on both sides.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream product is valid
//   in_product : unsigned 2*N-bit product
//   in_ready   : block accepts a product this cycle (state ACCUM)
//   tap_idx    : index of the next tap expected, selects sample/coef upstream
//   out_valid  : out_sum holds a completed sample (state OUT)
//   out_sum    : sum of TAPS products, ACC_W bits
//   out_ready  : downstream accepts out_sum
module tap_accumulator
  import equalizer_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int TAPS  = 8,
  localparam int ACC_W = acc_width(N, TAPS),
  localparam int IDX_W = $clog2(TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*N-1:0]     in_product,
  output logic               in_ready,
  output logic [IDX_W-1:0]   tap_idx,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_sum,
  input  logic               out_ready
);

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [ACC_W-1:0] sum_q,   sum_d;

  logic             accept;
  logic [ACC_W-1:0] prod_ext;

  // Handshake outputs decode registered state only, so neither in_valid nor
  // out_ready has a combinational path to in_ready/out_valid.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign tap_idx   = idx_q;
  assign out_sum   = sum_q;

  assign accept   = in_valid && in_ready;
  assign prod_ext = ACC_W'(in_product);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;

    if (accept) begin
      if (idx_q == LAST_TAP) begin
        // Last product goes straight into out_sum so the accumulator can be
        // cleared in the same cycle, ready for the next frame.
        sum_d   = acc_q + prod_ext;
        acc_d   = '0;
        idx_d   = '0;
        state_d = ST_OUT;
      end else begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 1'b1;
      end
    end

    if (state_q == ST_OUT && out_ready) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_tap_accumulator.sv
// Directed testbench for tap_accumulator at default parameters (N=4, TAPS=8).
module tb_tap_accumulator;

  localparam int N     = 4;
  localparam int TAPS  = 8;
  localparam int ACC_W = 11;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [2*N-1:0]   in_product;
  logic             in_ready;
  logic [IDX_W-1:0] tap_idx;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic             out_ready;

  int vectors     = 0;
  int miscompares = 0;

  tap_accumulator #(.N(N), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_product (in_product),
    .in_ready   (in_ready),
    .tap_idx    (tap_idx),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present 'n' products of value 'val' with in_valid held high.
  task automatic send_frame(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b1;
      in_product = 8'(val);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_tap_idx",   int'(tap_idx),   0);

    // Full scale: 8 x 225 -> 1800, tap_idx steps 0..7 then 0
    out_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      chk($sformatf("fs_tap_idx%0d", i), int'(tap_idx), i);
      in_valid   = 1'b1;
      in_product = 8'd225;
      tick();
    end
    in_valid = 1'b0;
    chk("fs_out_valid", int'(out_valid), 1);
    chk("fs_out_sum",   int'(out_sum),   1800);
    chk("fs_in_ready",  int'(in_ready),  0);
    chk("fs_tap_wrap",  int'(tap_idx),   0);
    tick();
    chk("fs_release_valid", int'(out_valid), 0);
    chk("fs_release_ready", int'(in_ready),  1);

    // Gaps: products 1..8 with idle cycles carrying junk data -> 36
    for (int k = 1; k < TAPS; k++) begin
      in_valid   = 1'b1;
      in_product = 8'(k);
      tick();
      in_valid   = 1'b0;
      in_product = 8'd99;
      tick();
      chk($sformatf("gap_tap_idx%0d", k), int'(tap_idx), k);
    end
    in_valid   = 1'b1;
    in_product = 8'd8;
    tick();
    in_valid = 1'b0;
    chk("gap_out_valid", int'(out_valid), 1);
    chk("gap_out_sum",   int'(out_sum),   36);
    tick();

    // Backpressure: 8 x 5 -> 40, held for 5 cycles while junk is offered
    out_ready = 1'b0;
    send_frame(5, TAPS);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), int'(out_valid), 1);
      chk($sformatf("bp_sum%0d", c),   int'(out_sum),   40);
      chk($sformatf("bp_ready%0d", c), int'(in_ready),  0);
      in_valid   = 1'b1;
      in_product = 8'd200;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_hold_valid", int'(out_valid), 1);
    chk("bp_hold_sum",   int'(out_sum),   40);
    tick();
    chk("bp_released", int'(out_valid), 0);
    chk("bp_ready",    int'(in_ready),  1);
    chk("bp_tap_idx",  int'(tap_idx),   0);

    // Back-to-back: A = 8 x 10 -> 80, B = 8 x 3 -> 24; B is offered during OUT
    send_frame(10, TAPS);
    chk("b2b_a_valid", int'(out_valid), 1);
    chk("b2b_a_sum",   int'(out_sum),   80);
    in_valid   = 1'b1;
    in_product = 8'd3;
    tick();
    chk("b2b_gap_ready", int'(in_ready), 1);
    chk("b2b_gap_idx",   int'(tap_idx),  0);
    send_frame(3, TAPS);
    chk("b2b_b_valid", int'(out_valid), 1);
    chk("b2b_b_sum",   int'(out_sum),   24);
    tick();

    // Reset mid-frame: 5 x 100 discarded, then 8 x 2 -> 16
    send_frame(100, 5);
    chk("rmid_idx_pre", int'(tap_idx), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_idx",   int'(tap_idx),   0);
    chk("rmid_ready", int'(in_ready),  1);
    chk("rmid_valid", int'(out_valid), 0);
    send_frame(2, TAPS);
    chk("rmid_out_valid", int'(out_valid), 1);
    chk("rmid_out_sum",   int'(out_sum),   16);
    tick();
    chk("rmid_single", int'(out_valid), 0);

    // Reset in OUT: pending 8 x 7 = 56 is dropped
    out_ready = 1'b0;
    send_frame(7, TAPS);
    chk("rout_pre_valid", int'(out_valid), 1);
    chk("rout_pre_sum",   int'(out_sum),   56);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rout_valid", int'(out_valid), 0);
    chk("rout_sum",   int'(out_sum),   0);
    chk("rout_ready", int'(in_ready),  1);
    tick();
    tick();
    chk("rout_no_pulse", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
